// File: rtl/l2_mshr_pool_pkg.sv
// Shared definitions for the L2 MSHR pool: the default entry layout, the
// invalid-state constant, the default entry count and the index-width helper.
package l2_mshr_pool_pkg;

  localparam int unsigned N_REQS        = 4;
  localparam int unsigned DEF_TAG_W     = 20;
  localparam int unsigned DEF_SET_W     = 8;
  localparam int unsigned DEF_WAY_W     = 3;
  localparam int unsigned DEF_STATE_W   = 4;
  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned DEF_PAYLOAD_W = 64;

  localparam logic [DEF_STATE_W-1:0] STATE_INVALID = '0;

  // Entry layout at the default widths; the pool re-declares the same layout
  // with its own parameter widths for storage.
  typedef struct packed {
    logic                     valid;
    logic [DEF_TAG_W-1:0]     tag;
    logic [DEF_SET_W-1:0]     set;
    logic [DEF_WAY_W-1:0]     way;
    logic [DEF_STATE_W-1:0]   state;
    logic [DEF_CNT_W-1:0]     invack_cnt;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } mshr_entry_t;

  // Index width for n entries, never below one bit.
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l2_mshr_prio_enc.sv
// Lowest-index-first priority encoder.
module l2_mshr_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan upward and keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/l2_mshr_pool.sv
// L2 miss-status / request buffer pool.
// Optional statistics outputs (stat_peak, stat_full_stall) are built when
// L2_MSHR_STATS_EN is defined.
module l2_mshr_pool
  import l2_mshr_pool_pkg::*;
#(
  parameter  int unsigned N_ENTRIES = N_REQS,
  parameter  int unsigned TAG_W     = 20,
  parameter  int unsigned SET_W     = 8,
  parameter  int unsigned WAY_W     = 3,
  parameter  int unsigned STATE_W   = 4,
  parameter  int unsigned CNT_W     = 4,
  parameter  int unsigned PAYLOAD_W = 64,
  localparam int unsigned IDX_W     = calc_idx_w(N_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [TAG_W-1:0]               alloc_tag,
  input  logic [SET_W-1:0]               alloc_set,
  input  logic [WAY_W-1:0]               alloc_way,
  input  logic [STATE_W-1:0]             alloc_state,
  input  logic [PAYLOAD_W-1:0]           alloc_payload,
  output logic [IDX_W-1:0]               alloc_idx,
  input  logic [TAG_W-1:0]               lkp_tag,
  input  logic [SET_W-1:0]               lkp_set,
  output logic                           lkp_hit,
  output logic [IDX_W-1:0]               lkp_idx,
  output logic                           set_conflict,
  input  logic                           upd_valid,
  input  logic [IDX_W-1:0]               upd_idx,
  input  logic [STATE_W-1:0]             upd_state,
  input  logic                           invack_dec,
  input  logic [IDX_W-1:0]               invack_idx,
  input  logic                           invack_load,
  input  logic [CNT_W-1:0]               invack_val,
  output logic [N_ENTRIES-1:0]           invack_zero,
  input  logic                           free_valid,
  input  logic [IDX_W-1:0]               free_idx,
  input  logic                           fwd_set,
  input  logic                           fwd_clr,
  input  logic [IDX_W-1:0]               fwd_idx,
  output logic                           fwd_stall,
  output logic [IDX_W-1:0]               fwd_stall_idx,
  output logic [IDX_W:0]                 occupancy,
  output logic                           full,
  output logic                           empty,
  output logic [N_ENTRIES*STATE_W-1:0]   entry_state,
  output logic [N_ENTRIES*PAYLOAD_W-1:0] entry_payload
`ifdef L2_MSHR_STATS_EN
  ,
  output logic [IDX_W:0]                 stat_peak,
  output logic [31:0]                    stat_full_stall
`endif
);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [SET_W-1:0]     set;
    logic [WAY_W-1:0]     way;
    logic [STATE_W-1:0]   state;
    logic [CNT_W-1:0]     invack_cnt;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t                 entries_q [N_ENTRIES];
  entry_t                 entries_d [N_ENTRIES];
  logic [IDX_W:0]         occ_q, occ_d;
  logic                   fwd_stall_q, fwd_stall_d;
  logic [IDX_W-1:0]       fwd_stall_idx_q, fwd_stall_idx_d;

  logic [N_ENTRIES-1:0]   free_vec;
  logic [N_ENTRIES-1:0]   match_vec;
  logic [N_ENTRIES-1:0]   free_hit;
  logic                   alloc_fire;
  logic [IDX_W:0]         free_cnt;

  // Per-entry status vectors derived from registered contents.
  always_comb begin
    free_vec     = '0;
    match_vec    = '0;
    set_conflict = 1'b0;
    invack_zero  = '0;
    entry_state  = '0;
    entry_payload = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      free_vec[i]  = !entries_q[i].valid;
      match_vec[i] = entries_q[i].valid && (entries_q[i].state != STATE_W'(STATE_INVALID)) &&
                     (entries_q[i].tag == lkp_tag) && (entries_q[i].set == lkp_set);
      if (entries_q[i].valid && (entries_q[i].set == lkp_set)) set_conflict = 1'b1;
      invack_zero[i] = (entries_q[i].invack_cnt == '0);
      entry_state[i*STATE_W +: STATE_W]       = entries_q[i].state;
      entry_payload[i*PAYLOAD_W +: PAYLOAD_W] = entries_q[i].payload;
    end
  end

  l2_mshr_prio_enc #(.N(N_ENTRIES), .W(IDX_W)) u_alloc_enc (
    .req   (free_vec),
    .found (alloc_ready),
    .idx   (alloc_idx)
  );

  l2_mshr_prio_enc #(.N(N_ENTRIES), .W(IDX_W)) u_lkp_enc (
    .req   (match_vec),
    .found (lkp_hit),
    .idx   (lkp_idx)
  );

  assign alloc_fire = alloc_valid && alloc_ready;

  // Entry updates. Only valid entries respond to free/update/invack, so an
  // allocation (always into an invalid entry) never collides with them;
  // per entry the priority is free, then update, then invack load, then dec.
  always_comb begin
    free_hit = '0;
    free_cnt = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if ((free_valid && (free_idx == IDX_W'(i))) ||
            (upd_valid && (upd_idx == IDX_W'(i)) && (upd_state == STATE_W'(STATE_INVALID)))) begin
          free_hit[i]        = 1'b1;
          free_cnt           = free_cnt + 1'b1;
          entries_d[i].valid = 1'b0;
          entries_d[i].state = STATE_W'(STATE_INVALID);
        end else if (upd_valid && (upd_idx == IDX_W'(i))) begin
          entries_d[i].state = upd_state;
        end else if (invack_load && (upd_idx == IDX_W'(i))) begin
          entries_d[i].invack_cnt = invack_val;
        end else if (invack_dec && (invack_idx == IDX_W'(i)) && (entries_q[i].invack_cnt != '0)) begin
          entries_d[i].invack_cnt = entries_q[i].invack_cnt - 1'b1;
        end
      end else if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
        entries_d[i].valid      = 1'b1;
        entries_d[i].tag        = alloc_tag;
        entries_d[i].set        = alloc_set;
        entries_d[i].way        = alloc_way;
        entries_d[i].state      = alloc_state;
        entries_d[i].invack_cnt = '1;
        entries_d[i].payload    = alloc_payload;
      end
    end
    occ_d = occ_q + (IDX_W+1)'(alloc_fire) - free_cnt;
  end

  // Forward-stall tracker: clear wins over set; freeing the tracked entry clears.
  always_comb begin
    fwd_stall_d     = fwd_stall_q;
    fwd_stall_idx_d = fwd_stall_idx_q;
    if (fwd_clr) begin
      fwd_stall_d = 1'b0;
    end else if (fwd_set) begin
      fwd_stall_d     = 1'b1;
      fwd_stall_idx_d = fwd_idx;
    end else if (fwd_stall_q && free_hit[fwd_stall_idx_q]) begin
      fwd_stall_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) entries_q[i] <= '0;
      occ_q           <= '0;
      fwd_stall_q     <= 1'b0;
      fwd_stall_idx_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) entries_q[i] <= entries_d[i];
      occ_q           <= occ_d;
      fwd_stall_q     <= fwd_stall_d;
      fwd_stall_idx_q <= fwd_stall_idx_d;
    end
  end

  assign occupancy     = occ_q;
  assign full          = (occ_q == (IDX_W+1)'(N_ENTRIES));
  assign empty         = (occ_q == '0);
  assign fwd_stall     = fwd_stall_q;
  assign fwd_stall_idx = fwd_stall_idx_q;

`ifdef L2_MSHR_STATS_EN
  logic [IDX_W:0] peak_q, peak_d;
  logic [31:0]    stall_q, stall_d;

  // Peak occupancy tracks the next-cycle value; stall count saturates.
  always_comb begin
    peak_d  = (occ_d > peak_q) ? occ_d : peak_q;
    stall_d = stall_q;
    if (alloc_valid && !alloc_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      peak_q  <= peak_d;
      stall_q <= stall_d;
    end
  end

  assign stat_peak       = peak_q;
  assign stat_full_stall = stall_q;
`endif

endmodule

// File: tb/tb_l2_mshr_pool.sv
// Self-checking bench for l2_mshr_pool at default parameters (4 entries).
module tb_l2_mshr_pool;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [19:0]  alloc_tag;
  logic [7:0]   alloc_set;
  logic [2:0]   alloc_way;
  logic [3:0]   alloc_state;
  logic [63:0]  alloc_payload;
  logic [1:0]   alloc_idx;
  logic [19:0]  lkp_tag;
  logic [7:0]   lkp_set;
  logic         lkp_hit;
  logic [1:0]   lkp_idx;
  logic         set_conflict;
  logic         upd_valid;
  logic [1:0]   upd_idx;
  logic [3:0]   upd_state;
  logic         invack_dec;
  logic [1:0]   invack_idx;
  logic         invack_load;
  logic [3:0]   invack_val;
  logic [3:0]   invack_zero;
  logic         free_valid;
  logic [1:0]   free_idx;
  logic         fwd_set;
  logic         fwd_clr;
  logic [1:0]   fwd_idx;
  logic         fwd_stall;
  logic [1:0]   fwd_stall_idx;
  logic [2:0]   occupancy;
  logic         full;
  logic         empty;
  logic [15:0]  entry_state;
  logic [255:0] entry_payload;
`ifdef L2_MSHR_STATS_EN
  logic [2:0]   stat_peak;
  logic [31:0]  stat_full_stall;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [1:0]  exp_idx_q[$];
  logic [1:0]  exp_idx;

  always #5 clk = ~clk;

  l2_mshr_pool dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .alloc_set(alloc_set), .alloc_way(alloc_way),
    .alloc_state(alloc_state), .alloc_payload(alloc_payload), .alloc_idx(alloc_idx),
    .lkp_tag(lkp_tag), .lkp_set(lkp_set), .lkp_hit(lkp_hit), .lkp_idx(lkp_idx),
    .set_conflict(set_conflict),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
    .invack_dec(invack_dec), .invack_idx(invack_idx),
    .invack_load(invack_load), .invack_val(invack_val), .invack_zero(invack_zero),
    .free_valid(free_valid), .free_idx(free_idx),
    .fwd_set(fwd_set), .fwd_clr(fwd_clr), .fwd_idx(fwd_idx),
    .fwd_stall(fwd_stall), .fwd_stall_idx(fwd_stall_idx),
    .occupancy(occupancy), .full(full), .empty(empty),
    .entry_state(entry_state), .entry_payload(entry_payload)
`ifdef L2_MSHR_STATS_EN
    , .stat_peak(stat_peak), .stat_full_stall(stat_full_stall)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_tag = '0; alloc_set = '0; alloc_way = '0;
    alloc_state = '0; alloc_payload = '0;
    upd_valid = 0; upd_idx = '0; upd_state = '0;
    invack_dec = 0; invack_idx = '0; invack_load = 0; invack_val = '0;
    free_valid = 0; free_idx = '0;
    fwd_set = 0; fwd_clr = 0; fwd_idx = '0;
  endtask

  // Compare alloc_idx against the scoreboard when the handshake will fire.
  task automatic alloc_edge();
    if (alloc_valid && alloc_ready) begin
      checks++;
      if (exp_idx_q.size() == 0) begin
        errors++; $display("FAIL alloc_sb unexpected accept idx=%0d", alloc_idx);
      end else begin
        exp_idx = exp_idx_q.pop_front();
        if (alloc_idx !== exp_idx) begin
          errors++; $display("FAIL alloc_idx got=%0d exp=%0d", alloc_idx, exp_idx);
        end
      end
    end
    step();
  endtask

  task automatic test_reset();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%0b exp=0", full); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", alloc_ready); end
    checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL rst_alloc_idx got=%0d exp=0", alloc_idx); end
    checks++; if (fwd_stall !== 1'b0 || fwd_stall_idx !== 2'd0) begin
      errors++; $display("FAIL rst_fwd got=%0b/%0d exp=0/0", fwd_stall, fwd_stall_idx); end
    checks++; if (invack_zero !== 4'b1111) begin errors++; $display("FAIL rst_invack_zero got=%b exp=1111", invack_zero); end
  endtask

  task automatic test_alloc_fill();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1; alloc_tag = 20'h10 + 20'(i); alloc_set = 8'd5;
      alloc_way = 3'(i); alloc_state = 4'd1; alloc_payload = 64'hA000 + 64'(i);
      exp_idx_q.push_back(2'(i));
      alloc_edge();
    end
    alloc_valid = 0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", full); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%0b exp=0", alloc_ready); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    checks++; if (entry_payload[191:128] !== 64'hA002) begin
      errors++; $display("FAIL fill_payload2 got=%0h exp=a002", entry_payload[191:128]); end
`ifdef L2_MSHR_STATS_EN
    checks++; if (stat_peak !== 3'd4) begin errors++; $display("FAIL stat_peak got=%0d exp=4", stat_peak); end
`endif
  endtask

  task automatic test_lookup();
    lkp_tag = 20'h12; lkp_set = 8'd5; #1;
    checks++; if (lkp_hit !== 1'b1 || lkp_idx !== 2'd2) begin
      errors++; $display("FAIL lkp_hit got=%0b/%0d exp=1/2", lkp_hit, lkp_idx); end
    checks++; if (set_conflict !== 1'b1) begin errors++; $display("FAIL lkp_conflict got=%0b exp=1", set_conflict); end
    lkp_set = 8'd6; #1;
    checks++; if (lkp_hit !== 1'b0 || set_conflict !== 1'b0) begin
      errors++; $display("FAIL lkp_miss got=%0b/%0b exp=0/0", lkp_hit, set_conflict); end
  endtask

  task automatic test_full_free();
    alloc_valid = 1; alloc_tag = 20'h20; alloc_set = 8'd5; alloc_state = 4'd3;
    alloc_payload = 64'hBEEF;
    free_valid = 1; free_idx = 2'd1;
    exp_idx_q.push_back(2'd1);
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL ff_refused got=%0b exp=0", alloc_ready); end
    alloc_edge();
    free_valid = 0;
    checks++; if (occupancy !== 3'd3 || alloc_idx !== 2'd1) begin
      errors++; $display("FAIL ff_after_free got=%0d/%0d exp=3/1", occupancy, alloc_idx); end
    alloc_edge();
    alloc_valid = 0;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL ff_occ got=%0d exp=4", occupancy); end
    checks++; if (exp_idx_q.size() != 0) begin errors++; $display("FAIL ff_sb_left got=%0d exp=0", exp_idx_q.size()); end
    lkp_tag = 20'h20; lkp_set = 8'd5; #1;
    checks++; if (lkp_hit !== 1'b1 || lkp_idx !== 2'd1) begin
      errors++; $display("FAIL ff_lkp got=%0b/%0d exp=1/1", lkp_hit, lkp_idx); end
`ifdef L2_MSHR_STATS_EN
    checks++; if (stat_full_stall !== 32'd1) begin errors++; $display("FAIL stat_stall got=%0d exp=1", stat_full_stall); end
`endif
  endtask

  task automatic test_invack();
    checks++; if (invack_zero !== 4'b0000) begin errors++; $display("FAIL ia_init got=%b exp=0000", invack_zero); end
    invack_load = 1; upd_idx = 2'd0; invack_val = 4'd2; step();
    invack_load = 0; invack_dec = 1; invack_idx = 2'd0;
    checks++; if (invack_zero[0] !== 1'b0) begin errors++; $display("FAIL ia_load2 got=%b exp=0", invack_zero[0]); end
    step();
    checks++; if (invack_zero[0] !== 1'b0) begin errors++; $display("FAIL ia_dec1 got=%b exp=0", invack_zero[0]); end
    step();
    checks++; if (invack_zero !== 4'b0001) begin errors++; $display("FAIL ia_dec0 got=%b exp=0001", invack_zero); end
    step();
    checks++; if (invack_zero !== 4'b0001) begin errors++; $display("FAIL ia_sat got=%b exp=0001", invack_zero); end
    invack_load = 1; invack_val = 4'd3; step();
    invack_load = 0;
    checks++; if (invack_zero[0] !== 1'b0) begin errors++; $display("FAIL ia_load_wins got=%b exp=0", invack_zero[0]); end
    step(); step();
    checks++; if (invack_zero[0] !== 1'b0) begin errors++; $display("FAIL ia_from3_1 got=%b exp=0", invack_zero[0]); end
    step();
    checks++; if (invack_zero[0] !== 1'b1) begin errors++; $display("FAIL ia_from3_0 got=%b exp=1", invack_zero[0]); end
    invack_dec = 0; invack_load = 1; invack_val = 4'd1; step();
    invack_load = 0; upd_valid = 1; upd_state = 4'd2; invack_dec = 1; step();
    upd_valid = 0; invack_dec = 0;
    checks++; if (invack_zero[0] !== 1'b0) begin errors++; $display("FAIL ia_upd_wins got=%b exp=0", invack_zero[0]); end
    checks++; if (entry_state[3:0] !== 4'd2) begin errors++; $display("FAIL upd_state got=%0d exp=2", entry_state[3:0]); end
  endtask

  task automatic test_fwd_free();
    fwd_set = 1; fwd_idx = 2'd3; step();
    fwd_set = 0;
    checks++; if (fwd_stall !== 1'b1 || fwd_stall_idx !== 2'd3) begin
      errors++; $display("FAIL fwd_set got=%0b/%0d exp=1/3", fwd_stall, fwd_stall_idx); end
    free_valid = 1; free_idx = 2'd3; step();
    checks++; if (fwd_stall !== 1'b0 || occupancy !== 3'd3) begin
      errors++; $display("FAIL fwd_free got=%0b/%0d exp=0/3", fwd_stall, occupancy); end
    step();
    free_valid = 0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL free_invalid got=%0d exp=3", occupancy); end
    fwd_set = 1; fwd_clr = 1; fwd_idx = 2'd0; step();
    fwd_set = 0; fwd_clr = 0;
    checks++; if (fwd_stall !== 1'b0) begin errors++; $display("FAIL fwd_clr_wins got=%0b exp=0", fwd_stall); end
    upd_valid = 1; upd_idx = 2'd2; upd_state = 4'd0; step();
    upd_valid = 0;
    lkp_tag = 20'h12; lkp_set = 8'd5; #1;
    checks++; if (occupancy !== 3'd2 || lkp_hit !== 1'b0) begin
      errors++; $display("FAIL upd_free got=%0d/%0b exp=2/0", occupancy, lkp_hit); end
    checks++; if (alloc_idx !== 2'd2 || set_conflict !== 1'b1) begin
      errors++; $display("FAIL upd_free_idx got=%0d/%0b exp=2/1", alloc_idx, set_conflict); end
  endtask

  task automatic test_reset_mid();
    alloc_valid = 1; alloc_tag = 20'h30; alloc_set = 8'd9; alloc_state = 4'd1;
    exp_idx_q.push_back(2'd2);
    alloc_edge();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL burst_occ got=%0d exp=3", occupancy); end
    rst = 0; #1;
    checks++; if (occupancy !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL mid_rst_occ got=%0d/%0b/%0b exp=0/1/0", occupancy, empty, full); end
    checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 2'd0) begin
      errors++; $display("FAIL mid_rst_alloc got=%0b/%0d exp=1/0", alloc_ready, alloc_idx); end
    checks++; if (invack_zero !== 4'b1111 || entry_state !== 16'h0) begin
      errors++; $display("FAIL mid_rst_entries got=%b/%0h exp=1111/0", invack_zero, entry_state); end
`ifdef L2_MSHR_STATS_EN
    checks++; if (stat_peak !== 3'd0 || stat_full_stall !== 32'd0) begin
      errors++; $display("FAIL mid_rst_stats got=%0d/%0d exp=0/0", stat_peak, stat_full_stall); end
`endif
    alloc_valid = 0;
    step();
    rst = 1;
    alloc_valid = 1; alloc_tag = 20'h40;
    exp_idx_q.push_back(2'd0);
    alloc_edge();
    alloc_valid = 0;
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL post_rst_occ got=%0d exp=1", occupancy); end
  endtask

  initial begin
    idle_inputs();
    lkp_tag = '0; lkp_set = '0;
    rst = 0;
    #1;
    test_reset();
    step(); step();
    rst = 1;
    step();
    test_reset();
    test_alloc_fill();
    test_lookup();
    test_full_free();
    test_invack();
    test_fwd_free();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/l2_mshr_pool.md
Name: l2_mshr_pool

Overview:
Parametrised L2 miss-status/request buffer holding up to N_ENTRIES outstanding CPU requests. It replaces the fixed-depth request buffer and adds:
- explicit valid bits and occupancy/full/empty status;
- a ready/valid allocate handshake;
- per-entry state update, invalidation-ack counting and free ports;
- a registered forward-stall tracker.
It sits between the L2 CPU-request path and the coherence message handlers.

Parameters:
N_ENTRIES, 4, number of entries; power of two, 2..16
TAG_W, 20, tag width
SET_W, 8, set index width
WAY_W, 3, way index width
STATE_W, 4, unstable-state encoding width; value 0 means INVALID
CNT_W, 4, invalidation-ack counter width
PAYLOAD_W, 64, opaque request payload (cpu_msg, hsize, hprot, offsets, word)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
alloc_valid  in  1  allocation request
alloc_ready  out  1  a free entry exists
alloc_tag/alloc_set/alloc_way  in  TAG_W/SET_W/WAY_W  fields for the new entry
alloc_state  in  STATE_W  initial state; must be non-zero
alloc_payload  in  PAYLOAD_W  payload for the new entry
alloc_idx  out  IDX_W=$clog2(N_ENTRIES)  index the next allocation will use
lkp_tag/lkp_set  in  TAG_W/SET_W  lookup key
lkp_hit  out  1  a valid entry matches tag and set
lkp_idx  out  IDX_W  index of the matching entry
set_conflict  out  1  a valid entry has set == lkp_set
upd_valid/upd_idx/upd_state  in  1/IDX_W/STATE_W  state write
invack_dec/invack_idx  in  1/IDX_W  decrement invack count
invack_load/invack_val  in  1/CNT_W  load invack count of upd_idx
invack_zero  out  N_ENTRIES  per-entry flag: count == 0
free_valid/free_idx  in  1/IDX_W  release an entry
fwd_set/fwd_clr/fwd_idx  in  1/1/IDX_W  forward-stall control
fwd_stall/fwd_stall_idx  out  1/IDX_W  registered forward-stall status
occupancy  out  IDX_W+1  number of valid entries
full/empty  out  1/1  occupancy == N_ENTRIES / occupancy == 0
entry_state  out  N_ENTRIES*STATE_W  packed per-entry state for the controller
entry_payload  out  N_ENTRIES*PAYLOAD_W  packed per-entry payload

Behaviour:
- Reset (rst low, asynchronous): every valid bit, state, tag, set, way, payload and counter clears to 0. Reset values: occupancy=0, empty=1, full=0, alloc_ready=1, alloc_idx=0, fwd_stall=0, fwd_stall_idx=0. Invack counts reset to 0, so invack_zero resets to all ones.
- Allocation is accepted when alloc_valid && alloc_ready. The entry at alloc_idx is written at that clock edge and is visible to lookup next cycle. alloc_idx is the lowest-index free entry. The invack count loads to its all-ones maximum on allocation.
- Lookup is combinational on registered contents. If several entries match, the lowest index wins. Entries with state 0 never match.
- upd_valid writes the state of upd_idx. Writing state 0 through this port also frees the entry.
- invack_dec saturates at 0. If invack_load and invack_dec target the same entry in the same cycle, the load wins.
- free_valid clears the valid bit and state of free_idx. Freeing an invalid entry is ignored and occupancy is unchanged.
- Same-cycle collisions on one index: free beats update, and update beats invack.
- Allocation and free in the same cycle: occupancy is unchanged. When full, a same-cycle free does not raise alloc_ready until the next cycle.
- Occupancy is a register updated by +alloc −free; it never wraps.
- Forward stall:
  - fwd_set sets fwd_stall=1 and latches fwd_idx.
  - fwd_clr clears fwd_stall.
  - If both are asserted, fwd_clr wins.
  - Freeing the entry equal to fwd_stall_idx while fwd_stall=1 also clears fwd_stall.

Optional Feature:
L2_MSHR_STATS_EN
- Defined: adds outputs stat_peak (IDX_W+1 bits, maximum occupancy since reset) and stat_full_stall (32 bits, saturating count of cycles with alloc_valid && !alloc_ready). Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared cache package gets:
  - the mshr_entry_t struct (valid, tag, set, way, state, invack_cnt, payload);
  - the STATE_INVALID=0 constant;
  - the N_REQS default;
  - the IDX_W function.
- Sub-module l2_mshr_prio_enc: parametrised lowest-index-first priority encoder, used for alloc_idx and lkp_idx.

Test Plan:
- Reset, then allocate 4 entries (N_ENTRIES=4) with tags 0x10..0x13 and set 5 → alloc_idx sequence 0,1,2,3; full=1, alloc_ready=0, occupancy=4.
- Lookup tag 0x12, set 5 → lkp_hit=1, lkp_idx=2, set_conflict=1. Lookup set 6 → lkp_hit=0, set_conflict=0.
- When full, assert free idx1 and alloc_valid in the same cycle → allocation refused. Next cycle alloc_idx=1 and the allocation succeeds; occupancy stays 4.
- On entry 0: load invack 2, then dec, dec, dec → counts 2,1,0,0 and invack_zero[0]=1. Load and dec in the same cycle → loaded value.
- fwd_set idx3, then free idx3 → fwd_stall falls to 0 in the following cycle. fwd_set and fwd_clr together → 0.
- Assert rst mid-allocation burst → all outputs return to their reset values immediately. With STATS_EN defined: stat_peak=4 after the first test and stat_full_stall counts refused cycles.
